// File: rtl/stopwatch_ctrl_if.sv
// Button/wrap inputs and sequencer outputs of the stopwatch front end.
// master = board/bench side, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_lr;
  logic       wrap;
  logic       count_en;
  logic       count_clr;
  logic       disp_hold;
  logic [1:0] state;

  modport master (output btn_ss, btn_lr, wrap,
                  input  count_en, count_clr, disp_hold, state);
  modport slave  (input  btn_ss, btn_lr, wrap,
                  output count_en, count_clr, disp_hold, state);
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: 2-FF sync + debounce per button, press events, 4-state FSM.
// Optional STOPWATCH_AUTOSTOP_EN: a wrap pulse in RUN/LAP forces STOP.

module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);
  logic [1:0]       sync;
  logic             lvl;
  logic [CNT_W-1:0] cnt;

  // cnt holds the number of consecutive cycles the synced level has
  // disagreed with lvl; the final increment is folded into the accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      lvl   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        lvl   <= sync[1];
        cnt   <= '0;
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);
  localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, LAP = 2'b10, STOP = 2'b11} state_t;

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] press;
  logic                 ss, lr;

  assign raw = {bus.btn_lr, bus.btn_ss};

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db [NUM_LANES-1:0] (
    .clock (clock),
    .reset (reset),
    .raw   (raw),
    .press (press)
  );

  assign ss = press[0];
  assign lr = press[1];

  state_t cur, nxt;
  logic   clr_nxt;
  logic   en_q, clr_q, hold_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur    <= IDLE;
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      cur    <= nxt;
      en_q   <= (nxt == RUN) || (nxt == LAP);
      clr_q  <= clr_nxt;
      hold_q <= (nxt == LAP);
    end
  end

  // ss is checked first everywhere so a coincident lr is dropped.
  always_comb begin
    nxt     = cur;
    clr_nxt = 1'b0;
    case (cur)
      IDLE: if (ss) nxt = RUN;
            else if (lr) clr_nxt = 1'b1;
      RUN:  if (ss) nxt = STOP;
            else if (lr) nxt = LAP;
      LAP:  if (ss) nxt = STOP;
            else if (lr) nxt = RUN;
      STOP: if (ss) nxt = RUN;
            else if (lr) begin
              nxt     = IDLE;
              clr_nxt = 1'b1;
            end
      default: nxt = IDLE;
    endcase
`ifdef STOPWATCH_AUTOSTOP_EN
    if (bus.wrap && ((cur == RUN) || (cur == LAP))) nxt = STOP;
`endif
  end

`ifndef STOPWATCH_AUTOSTOP_EN
  logic unused_wrap;
  assign unused_wrap = bus.wrap;
`endif

  assign bus.state     = cur;
  assign bus.count_en  = en_q;
  assign bus.count_clr = clr_q;
  assign bus.disp_hold = hold_q;
endmodule
